// File: rtl/rate_sel_pkg.sv
// rate_sel_pkg: shared period arithmetic, counter width derivation and FSM state encoding
//  period(base, sel)  period in clk cycles of channel sel (base << sel)
//  cnt_width(base, n) counter width able to hold every count of the slowest channel
//  RUN / PEND         rate-change state encoding (PEND drives pending_o)
package rate_sel_pkg;
    localparam logic RUN  = 1'b0;
    localparam logic PEND = 1'b1;
    function automatic longint period(longint base, int sel);
        return base << sel;
    endfunction
    function automatic int cnt_width(longint base, int n);
        return $clog2(base << (n - 1));
    endfunction
endpackage

// File: rtl/rate_select_tick_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a multi-bit quasi-static bus
//  clk  in  1  destination clock
//  rst  in  1  synchronous active-high reset, loads both stages with RST_VAL
//  d    in  W  asynchronous input
//  q    out W  synchronised output, 2-cycle latency
module sync_2ff #(
    parameter int W = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/rate_select_tick.sv
// rate_select_tick: switch-selected tick generator at DIV_BASE << k clocks, glitch-free rate changes
//  clk           in  1      system clock
//  rst           in  1      synchronous active-high reset
//  en            in  1      count enable; low freezes the counter and suppresses ticks
//  sw            in  SEL_W  asynchronous rate select
//  tick_o        out 1      one-cycle pulse per active period
//  active_sel_o  out SEL_W  channel currently generating ticks
//  pending_o     out 1      a rate change waits for the period boundary
//  square_o      out 1      50% square at the active rate, only when RATE_SEL_SQUARE_EN is defined
module rate_select_tick
    import rate_sel_pkg::*;
#(
    parameter int DIV_BASE = 12_500_000,
    parameter int N_CH     = 4,
    parameter int SEL_W    = 2,
    parameter int RST_SEL  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sw,
    output logic             tick_o,
    output logic [SEL_W-1:0] active_sel_o,
    output logic             pending_o
`ifdef RATE_SEL_SQUARE_EN
    ,
    output logic             square_o
`endif
);
    localparam int CNT_W = cnt_width(DIV_BASE, N_CH);
    localparam logic [CNT_W:0] ONE = 1;
    logic [SEL_W-1:0] sel_s, tgt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] p, cnt_x;
    logic state, change, term, commit;
    sync_2ff #(.W(SEL_W), .RST_VAL(SEL_W'(RST_SEL))) u_sync (
        .clk(clk),
        .rst(rst),
        .d(sw),
        .q(sel_s)
    );
    // Out-of-range selections count as "no change", so they cancel a pending request.
    always_comb begin
        p      = (CNT_W+1)'(period(DIV_BASE, int'(active_sel_o)));
        cnt_x  = {1'b0, cnt};
        change = ({1'b0, sel_s} < (SEL_W+1)'(N_CH)) && (sel_s != active_sel_o);
        term   = en && (cnt_x == p - ONE);
        commit = (state == PEND) && change && term;
    end
    assign pending_o = state;
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            tick_o       <= 1'b0;
            active_sel_o <= SEL_W'(RST_SEL);
            tgt          <= SEL_W'(RST_SEL);
            state        <= RUN;
        end else begin
            tick_o <= term;
            if (en) cnt <= term ? '0 : cnt + CNT_W'(1);
            if (state == RUN) begin
                if (change) begin
                    state <= PEND;
                    tgt   <= sel_s;
                end
            end else if (!change) begin
                state <= RUN;
            end else if (commit) begin
                active_sel_o <= tgt;
                state        <= RUN;
            end else begin
                tgt <= sel_s;
            end
        end
    end
`ifdef RATE_SEL_SQUARE_EN
    // Forced low on commit so every new rate starts with a low half-period.
    always_ff @(posedge clk) begin
        if (rst || commit) square_o <= 1'b0;
        else if (en && (cnt_x == (p >> 1) - ONE || cnt_x == p - ONE)) square_o <= ~square_o;
    end
`endif
endmodule

// File: tb/tb_rate_select_tick.sv
// tb_rate_select_tick: directed self-checking bench, DIV_BASE=4 N_CH=3 -> periods 4/8/16
module tb_rate_select_tick;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic [1:0] sw = 2'd0;
    logic tick_o, pending_o;
    logic [1:0] active_sel_o;
`ifdef RATE_SEL_SQUARE_EN
    logic square_o;
`endif
    int tests = 0;
    int fails = 0;

    rate_select_tick #(.DIV_BASE(4), .N_CH(3), .SEL_W(2), .RST_SEL(0)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sw(sw),
        .tick_o(tick_o),
        .active_sel_o(active_sel_o),
        .pending_o(pending_o)
`ifdef RATE_SEL_SQUARE_EN
        ,
        .square_o(square_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until tick_o is seen high, -1 if it never appears within the bound.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (tick_o) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        sw  = 2'd0;
        en  = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", tick_o); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", active_sel_o); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL reset_pending got %b want 0", pending_o); end
        tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
        for (int k = 0; k < 3; k++) begin
            wait_tick(n);
            tests++; if (n != 4) begin fails++; $display("FAIL reset_tick_spacing[%0d] got %0d want 4", k, n); end
        end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL run_sel got %0d want 0", active_sel_o); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL run_pending got %b want 0", pending_o); end
    endtask

    task automatic test_rate_change();
        int n;
        sw = 2'd2;
        step();
        step();
        step();
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL chg_pending got %b want 1", pending_o); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL chg_sel_before got %0d want 0", active_sel_o); end
        wait_tick(n);
        tests++; if (n != 1) begin fails++; $display("FAIL chg_old_tick got %0d want 1", n); end
        tests++; if (active_sel_o !== 2'd2) begin fails++; $display("FAIL chg_commit_sel got %0d want 2", active_sel_o); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL chg_commit_pending got %b want 0", pending_o); end
`ifdef RATE_SEL_SQUARE_EN
        tests++; if (square_o !== 1'b0) begin fails++; $display("FAIL chg_square_low got %b want 0", square_o); end
`endif
        for (int k = 0; k < 2; k++) begin
            wait_tick(n);
            tests++; if (n != 16) begin fails++; $display("FAIL chg_spacing[%0d] got %0d want 16", k, n); end
        end
        sw = 2'd0;
        wait_tick(n);
        tests++; if (n != 16) begin fails++; $display("FAIL back_spacing got %0d want 16", n); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL back_sel got %0d want 0", active_sel_o); end
    endtask

    task automatic test_glitch();
        int n;
        sw = 2'd1;
        step();
        sw = 2'd0;
        step();
        step();
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL glitch_pending got %b want 1", pending_o); end
        step();
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL glitch_cancel got %b want 0", pending_o); end
        tests++; if (tick_o !== 1'b1) begin fails++; $display("FAIL glitch_tick got %b want 1", tick_o); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL glitch_sel got %0d want 0", active_sel_o); end
        for (int k = 0; k < 2; k++) begin
            wait_tick(n);
            tests++; if (n != 4) begin fails++; $display("FAIL glitch_spacing[%0d] got %0d want 4", k, n); end
        end
    endtask

    task automatic test_invalid();
        int n;
        sw = 2'd3;
        for (int k = 1; k <= 4; k++) begin
            step();
            tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL inv_pending[%0d] got %b want 0", k, pending_o); end
        end
        tests++; if (tick_o !== 1'b1) begin fails++; $display("FAIL inv_tick got %b want 1", tick_o); end
        wait_tick(n);
        tests++; if (n != 4) begin fails++; $display("FAIL inv_spacing got %0d want 4", n); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL inv_sel got %0d want 0", active_sel_o); end
    endtask

    task automatic test_enable_freeze();
        int n;
        sw = 2'd0;
        step();
        sw = 2'd1;
        en = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL frz_tick[%0d] got %b want 0", k, tick_o); end
        end
        tests++; if (dut.cnt !== 4'd1) begin fails++; $display("FAIL frz_cnt got %0d want 1", dut.cnt); end
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL frz_pending got %b want 1", pending_o); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL frz_sel got %0d want 0", active_sel_o); end
        en = 1'b1;
        wait_tick(n);
        tests++; if (n != 3) begin fails++; $display("FAIL frz_stretch got %0d want 3", n); end
        tests++; if (active_sel_o !== 2'd1) begin fails++; $display("FAIL frz_commit_sel got %0d want 1", active_sel_o); end
        wait_tick(n);
        tests++; if (n != 8) begin fails++; $display("FAIL frz_new_spacing got %0d want 8", n); end
    endtask

    task automatic test_reset_pending();
        int n;
        sw = 2'd2;
        for (int k = 0; k < 6; k++) step();
        tests++; if (pending_o !== 1'b1) begin fails++; $display("FAIL rp_pending got %b want 1", pending_o); end
        tests++; if (dut.cnt !== 4'd6) begin fails++; $display("FAIL rp_cnt got %0d want 6", dut.cnt); end
        rst = 1'b1;
        sw  = 2'd0;
        step();
        rst = 1'b0;
        tests++; if (dut.cnt !== 4'd0) begin fails++; $display("FAIL rp_cnt_rst got %0d want 0", dut.cnt); end
        tests++; if (active_sel_o !== 2'd0) begin fails++; $display("FAIL rp_sel got %0d want 0", active_sel_o); end
        tests++; if (pending_o !== 1'b0) begin fails++; $display("FAIL rp_pending_rst got %b want 0", pending_o); end
        tests++; if (tick_o !== 1'b0) begin fails++; $display("FAIL rp_tick got %b want 0", tick_o); end
`ifdef RATE_SEL_SQUARE_EN
        begin
            logic [7:0] sq_exp;
            sq_exp = 8'b0110_0110;
            tests++; if (square_o !== 1'b0) begin fails++; $display("FAIL rp_square got %b want 0", square_o); end
            for (int k = 0; k < 8; k++) begin
                step();
                tests++; if (square_o !== sq_exp[7-k]) begin fails++; $display("FAIL square[%0d] got %b want %b", k, square_o, sq_exp[7-k]); end
            end
        end
`else
        wait_tick(n);
        tests++; if (n != 4) begin fails++; $display("FAIL rp_first_tick got %0d want 4", n); end
`endif
    endtask

    initial begin
        test_reset();
        test_rate_change();
        test_glitch();
        test_invalid();
        test_enable_freeze();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
